// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus between the fetch and data ports, one transaction outstanding at a time.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate grants when both ports request together.
module sram_bus_arbiter #(
  parameter int ADDR_WD = 32,
  parameter int DATA_WD = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_WD  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               inst_req,
  input  logic [ADDR_WD-1:0] inst_addr,
  output logic               inst_addr_ok,
  output logic               inst_data_ok,
  output logic [DATA_WD-1:0] inst_rdata,
  input  logic               data_req,
  input  logic               data_wr,
  input  logic [1:0]         data_size,
  input  logic [3:0]         data_wstrb,
  input  logic [ADDR_WD-1:0] data_addr,
  input  logic [DATA_WD-1:0] data_wdata,
  output logic               data_addr_ok,
  output logic               data_data_ok,
  output logic [DATA_WD-1:0] data_rdata,
  output logic               bus_req,
  output logic               bus_wr,
  output logic [1:0]         bus_size,
  output logic [3:0]         bus_wstrb,
  output logic [ADDR_WD-1:0] bus_addr,
  output logic [DATA_WD-1:0] bus_wdata,
  input  logic               bus_addr_ok,
  input  logic               bus_data_ok,
  input  logic [DATA_WD-1:0] bus_rdata,
  output logic               stallreq_if,
  output logic               stallreq_mem,
  output logic               bus_timeout
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  localparam logic [CNT_WD-1:0] TIMEOUT_C = CNT_WD'(TIMEOUT);
  localparam logic              WDOG_EN   = (TIMEOUT != 0);
  localparam logic [CNT_WD-1:0] CNT_ONE   = {{(CNT_WD-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic                owner_q, owner_d;     // 0 = inst, 1 = data
  logic                discard_q, discard_d;
  logic [CNT_WD-1:0]   wdog_cnt_q, wdog_cnt_d;
  logic                gnt_data;
  logic                handshake;
  logic                timeout_hit;
  logic                resp_fire;
  logic [DATA_WD-1:0]  resp_rdata;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner_q, last_owner_d;

  // Grant selection: alternate against the previous owner on contention
  always_comb begin
    if (inst_req & data_req) begin
      gnt_data = ~last_owner_q;
    end else begin
      gnt_data = data_req;
    end
    if (handshake) begin
      last_owner_d = gnt_data;
    end else begin
      last_owner_d = last_owner_q;
    end
  end

  // Previous-owner register
  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner_q <= 1'b0;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  // Grant selection: data port always wins
  always_comb begin
    gnt_data = data_req;
  end
`endif

  // Next-state, bus mux and response routing
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    discard_d    = discard_q;
    wdog_cnt_d   = wdog_cnt_q;
    handshake    = 1'b0;
    timeout_hit  = 1'b0;
    resp_fire    = 1'b0;
    resp_rdata   = '0;
    bus_req      = 1'b0;
    bus_wr       = 1'b0;
    bus_size     = 2'd0;
    bus_wstrb    = 4'b0000;
    bus_addr     = '0;
    bus_wdata    = '0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = '0;
    data_rdata   = '0;
    bus_timeout  = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus_req      = (inst_req | data_req) & ~reset;
        handshake    = bus_req & bus_addr_ok;
        inst_addr_ok = handshake & ~gnt_data;
        data_addr_ok = handshake & gnt_data;
        if (bus_req & gnt_data) begin
          bus_wr    = data_wr;
          bus_size  = data_size;
          bus_wstrb = data_wstrb;
          bus_addr  = data_addr;
          bus_wdata = data_wdata;
        end else if (bus_req) begin
          bus_size  = 2'd2;
          bus_addr  = inst_addr;
        end else begin
          bus_size  = 2'd0;
        end
        if (handshake) begin
          state_d    = S_WAIT;
          owner_d    = gnt_data;
          wdog_cnt_d = '0;
          discard_d  = flush & ~gnt_data;
        end else begin
          discard_d  = 1'b0;
        end
      end
      S_WAIT: begin
        // A real response in the same cycle as the watchdog takes precedence
        timeout_hit = WDOG_EN & (wdog_cnt_q == TIMEOUT_C) & ~bus_data_ok & ~reset;
        resp_fire   = (bus_data_ok & ~reset) | timeout_hit;
        bus_timeout = timeout_hit;
        wdog_cnt_d  = wdog_cnt_q + CNT_ONE;
        if (bus_data_ok) begin
          resp_rdata = bus_rdata;
        end else begin
          resp_rdata = '0;
        end
        if (flush & ~owner_q) begin
          discard_d = 1'b1;
        end else begin
          discard_d = discard_q;
        end
        if (resp_fire) begin
          state_d   = S_IDLE;
          discard_d = 1'b0;
          if (owner_q) begin
            data_data_ok = 1'b1;
            data_rdata   = resp_rdata;
          end else if (~(discard_q | flush)) begin
            inst_data_ok = 1'b1;
            inst_rdata   = resp_rdata;
          end else begin
            inst_data_ok = 1'b0;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d   = S_IDLE;
        discard_d = 1'b0;
      end
    endcase

    stallreq_mem = ~reset & ((data_req & ~data_addr_ok) |
                             ((state_q == S_WAIT) & owner_q & ~data_data_ok));
    stallreq_if  = ~reset & ((inst_req & ~inst_addr_ok) |
                             ((state_q == S_WAIT) & ~owner_q & ~inst_data_ok & ~discard_q));
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      discard_q  <= 1'b0;
      wdog_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      discard_q  <= discard_d;
      wdog_cnt_q <= wdog_cnt_d;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter: vector table of single transactions plus
// hand-written arbitration, flush, watchdog and reset sequences, checked through a scoreboard.
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = 32'h0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  data_size = 2'd0;
  logic [3:0]  data_wstrb = 4'h0;
  logic [31:0] data_addr = 32'h0, data_wdata = 32'h0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok = 1'b0, bus_data_ok = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        stallreq_if, stallreq_mem, bus_timeout;

  sram_bus_arbiter #(.ADDR_WD(32), .DATA_WD(32), .TIMEOUT(4), .CNT_WD(8)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem), .bus_timeout(bus_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_data;
    bit          wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  typedef struct {
    bit          is_data;
    bit          ok;
    logic [31:0] rdata;
  } exp_t;

  vec_t vecs[5];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  bit   inst_hold = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr();
    flush = 1'b0;
    if (!inst_hold) begin
      inst_req  = 1'b0;
      inst_addr = 32'h0;
    end
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_size   = 2'd0;
    data_wstrb  = 4'h0;
    data_addr   = 32'h0;
    data_wdata  = 32'h0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = 32'h0;
  endtask

  // Single-requester handshake cycle; pushes the expected response
  task automatic issue(input vec_t v, input bit exp_ok, input logic [31:0] exp_rdata);
    @(negedge clk);
    clr();
    if (v.is_data) begin
      data_req = 1'b1; data_wr = v.wr; data_size = v.size;
      data_wstrb = v.wstrb; data_addr = v.addr; data_wdata = v.wdata;
    end else begin
      inst_req = 1'b1; inst_addr = v.addr;
    end
    bus_addr_ok = 1'b1;
    #1;
    chk1("issue_bus_req", bus_req, 1'b1);
    chk1("issue_data_addr_ok", data_addr_ok, v.is_data);
    chk1("issue_inst_addr_ok", inst_addr_ok, !v.is_data);
    chk32("issue_bus_addr", bus_addr, v.addr);
    chk1("issue_bus_wr", bus_wr, v.is_data ? v.wr : 1'b0);
    chk32("issue_bus_size", 32'(bus_size), v.is_data ? 32'(v.size) : 32'd2);
    chk32("issue_bus_wstrb", 32'(bus_wstrb), v.is_data ? 32'(v.wstrb) : 32'd0);
    chk32("issue_bus_wdata", bus_wdata, v.is_data ? v.wdata : 32'h0);
    sb.push_back('{v.is_data, exp_ok, exp_rdata});
  endtask

  task automatic wait_cycles(input int n, input bit is_data, input bit exp_stall);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      clr();
      #1;
      chk1("wait_inst_data_ok", inst_data_ok, 1'b0);
      chk1("wait_data_data_ok", data_data_ok, 1'b0);
      chk1("wait_bus_req", bus_req, 1'b0);
      chk1("wait_bus_timeout", bus_timeout, 1'b0);
      chk1("wait_stall", is_data ? stallreq_mem : stallreq_if, exp_stall);
    end
  endtask

  // Response cycle: pops the scoreboard and compares the routed result
  task automatic respond(input bit dok, input logic [31:0] r, input bit exp_to);
    exp_t e;
    @(negedge clk);
    clr();
    bus_data_ok = dok;
    bus_rdata   = r;
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_empty: got no expected entry, required one");
    end else begin
      e = sb.pop_front();
      chk1("resp_inst_data_ok", inst_data_ok, !e.is_data && e.ok);
      chk1("resp_data_data_ok", data_data_ok, e.is_data && e.ok);
      chk32("resp_inst_rdata", inst_rdata, (!e.is_data && e.ok) ? e.rdata : 32'h0);
      chk32("resp_data_rdata", data_rdata, (e.is_data && e.ok) ? e.rdata : 32'h0);
      chk1("resp_bus_timeout", bus_timeout, exp_to);
      chk1("resp_stall", e.is_data ? stallreq_mem : stallreq_if, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    vecs[0] = '{1'b1, 1'b0, 2'd2, 4'hF, 32'h0000_1000, 32'h0,         32'h1234_5678, 2};
    vecs[1] = '{1'b0, 1'b0, 2'd2, 4'h0, 32'h1C00_0000, 32'h0,         32'hA5A5_0001, 1};
    vecs[2] = '{1'b1, 1'b1, 2'd2, 4'hF, 32'h0000_2004, 32'hCAFE_F00D, 32'h0,         0};
    vecs[3] = '{1'b1, 1'b0, 2'd0, 4'h0, 32'h0000_3003, 32'h0,         32'h0000_00EE, 3};
    vecs[4] = '{1'b0, 1'b0, 2'd2, 4'h0, 32'h1C00_0004, 32'h0,         32'h0280_0000, 0};

    // Reset with requests pending: stalls forced low
    inst_req = 1'b1; data_req = 1'b1; bus_addr_ok = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_stallreq_if", stallreq_if, 1'b0);
    chk1("rst_stallreq_mem", stallreq_mem, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    clr();
    #1;
    chk1("post_rst_bus_req", bus_req, 1'b0);
    chk1("post_rst_inst_addr_ok", inst_addr_ok, 1'b0);
    chk1("post_rst_data_data_ok", data_data_ok, 1'b0);
    chk1("post_rst_stallreq_mem", stallreq_mem, 1'b0);
    chk1("post_rst_bus_timeout", bus_timeout, 1'b0);

    for (int i = 0; i < 5; i++) begin
      issue(vecs[i], 1'b1, vecs[i].rdata);
      wait_cycles(vecs[i].lat, vecs[i].is_data, 1'b1);
      respond(1'b1, vecs[i].rdata, 1'b0);
    end

    // Contention: data first, inst on the cycle after data returns
    @(negedge clk);
    clr();
    inst_hold = 1'b1;
    inst_req = 1'b1; inst_addr = 32'h1C00_0100;
    data_req = 1'b1; data_addr = 32'h0000_4000; data_size = 2'd2;
    bus_addr_ok = 1'b1;
    #1;
    chk1("arb_data_first", data_addr_ok, 1'b1);
    chk1("arb_inst_held", inst_addr_ok, 1'b0);
    chk32("arb_bus_addr", bus_addr, 32'h0000_4000);
    chk1("arb_stallreq_if", stallreq_if, 1'b1);
    sb.push_back('{1'b1, 1'b1, 32'h1111_2222});
    respond(1'b1, 32'h1111_2222, 1'b0);
    @(negedge clk);
    clr();
    bus_addr_ok = 1'b1;
    #1;
    chk1("arb_inst_second", inst_addr_ok, 1'b1);
    chk32("arb_inst_bus_addr", bus_addr, 32'h1C00_0100);
    sb.push_back('{1'b0, 1'b1, 32'h3333_4444});
    inst_hold = 1'b0;
    respond(1'b1, 32'h3333_4444, 1'b0);

    // Fetch flushed while waiting: response swallowed, next request accepted at once
    v = '{1'b0, 1'b0, 2'd2, 4'h0, 32'h1C00_0200, 32'h0, 32'h0, 0};
    issue(v, 1'b0, 32'h0);
    @(negedge clk);
    clr();
    flush = 1'b1;
    #1;
    chk1("flush_cycle_inst_data_ok", inst_data_ok, 1'b0);
    wait_cycles(1, 1'b0, 1'b0);
    respond(1'b1, 32'hDEAD_BEEF, 1'b0);
    v = '{1'b1, 1'b0, 2'd2, 4'hF, 32'h0000_5000, 32'h0, 32'h7777_8888, 0};
    issue(v, 1'b1, 32'h7777_8888);
    respond(1'b1, 32'h7777_8888, 1'b0);

    // Store accepted then flush: still completes
    v = '{1'b1, 1'b1, 2'd1, 4'h3, 32'h0000_6002, 32'h0000_BEEF, 32'h0, 0};
    issue(v, 1'b1, 32'h0);
    @(negedge clk);
    clr();
    flush = 1'b1;
    #1;
    chk1("store_flush_stall", stallreq_mem, 1'b1);
    respond(1'b1, 32'h0, 1'b0);

    // Watchdog fires on the 5th waiting cycle
    v = '{1'b1, 1'b0, 2'd2, 4'hF, 32'h0000_7000, 32'h0, 32'h0, 0};
    issue(v, 1'b1, 32'h0);
    wait_cycles(4, 1'b1, 1'b1);
    respond(1'b0, 32'hFFFF_FFFF, 1'b1);
    v = '{1'b0, 1'b0, 2'd2, 4'h0, 32'h1C00_0300, 32'h0, 32'h0101_0101, 0};
    issue(v, 1'b1, 32'h0101_0101);
    respond(1'b1, 32'h0101_0101, 1'b0);

    // Real response coinciding with the watchdog wins
    v = '{1'b1, 1'b0, 2'd2, 4'hF, 32'h0000_8000, 32'h0, 32'h5A5A_5A5A, 0};
    issue(v, 1'b1, 32'h5A5A_5A5A);
    wait_cycles(4, 1'b1, 1'b1);
    respond(1'b1, 32'h5A5A_5A5A, 1'b0);

    // Reset mid-transaction: late response ignored
    v = '{1'b0, 1'b0, 2'd2, 4'h0, 32'h1C00_0400, 32'h0, 32'h0, 0};
    issue(v, 1'b1, 32'h0);
    void'(sb.pop_back());
    wait_cycles(1, 1'b0, 1'b1);
    @(negedge clk);
    clr();
    reset = 1'b1;
    #1;
    chk1("midrst_stallreq_if", stallreq_if, 1'b0);
    @(negedge clk);
    clr();
    reset = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata = 32'hC0DE_C0DE;
    #1;
    chk1("midrst_inst_data_ok", inst_data_ok, 1'b0);
    chk1("midrst_data_data_ok", data_data_ok, 1'b0);
    chk32("midrst_inst_rdata", inst_rdata, 32'h0);
    chk1("midrst_bus_req", bus_req, 1'b0);
    chk1("midrst_stallreq_if", stallreq_if, 1'b0);
    chk1("midrst_bus_timeout", bus_timeout, 1'b0);
    v = '{1'b0, 1'b0, 2'd2, 4'h0, 32'h1C00_0500, 32'h0, 32'h0202_0202, 0};
    issue(v, 1'b1, 32'h0202_0202);
    respond(1'b1, 32'h0202_0202, 1'b0);

    @(negedge clk);
    clr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
